// File: rtl/fetch_decode.sv
// Fetch/decode front end: fetches one word per instruction, decodes it and holds the
// decoded fields for the execute stage under a valid/ready handshake, with PC redirects.
module fetch_decode #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [3:0]  iss_alu_op,
  output logic [2:0]  iss_rd,
  output logic [2:0]  iss_ra,
  output logic [2:0]  iss_rb,
  output logic [15:0] iss_imm,
  output logic        iss_use_imm,
  output logic        iss_is_load,
  output logic        iss_is_store,
  output logic [15:0] iss_pc,
  output logic        illegal
);

  typedef enum logic [1:0] {StIdle, StFetch, StDecode, StIssue} state_e;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] imm;
    logic        use_imm;
    logic        is_load;
    logic        is_store;
    logic [15:0] pc;
  } iss_t;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  iss_t        iss_q, iss_d;

  iss_t        dec;
  logic        dec_bri, dec_illegal;
  logic [4:0]  opcode;
  logic [15:0] imm_sext, imm_zext;
  logic [15:0] pc_inc, br_target;

  // Instruction decode from IR; register ops carry imm = 0.
  always_comb begin
    opcode      = ir_q[15:11];
    imm_sext    = {{11{ir_q[4]}}, ir_q[4:0]};
    imm_zext    = {11'b0, ir_q[4:0]};
    pc_inc      = pc_q + 16'd1;
    br_target   = pc_q + 16'd1 + {{5{ir_q[10]}}, ir_q[10:0]};
    dec         = '0;
    dec.rd      = ir_q[10:8];
    dec.ra      = ir_q[7:5];
    dec.rb      = ir_q[4:2];
    dec.pc      = pc_q;
    dec_bri     = 1'b0;
    dec_illegal = 1'b0;
    if (opcode <= 5'd6) begin
      dec.alu_op = opcode[3:0];
    end else if (opcode <= 5'd13) begin
      dec.alu_op  = 4'(opcode - 5'd7);
      dec.use_imm = 1'b1;
      dec.imm     = (opcode <= 5'd8) ? imm_sext : imm_zext;
    end else if (opcode == 5'd14) begin
      dec_bri = 1'b1;
    end else if (opcode <= 5'd17) begin
      dec.alu_op = 4'(opcode - 5'd8);
    end else if (opcode <= 5'd19) begin
      dec.use_imm  = 1'b1;
      dec.imm      = imm_sext;
      dec.is_store = (opcode == 5'd18);
      dec.is_load  = (opcode == 5'd19);
    end else begin
      dec_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      pend_q    <= 1'b0;
      pend_pc_q <= 16'h0000;
      iss_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      iss_q     <= iss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    iss_d     = iss_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end
        // A redirect seen during this fetch makes the returned word stale.
        if (imem_ack) begin
          if (pend_d) begin
            pc_d   = pend_pc_d;
            pend_d = 1'b0;
          end else begin
            ir_d    = imem_data;
            state_d = StDecode;
          end
        end
      end
      StDecode: begin
        iss_d = dec;
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (dec_bri) begin
          pc_d    = br_target;
          state_d = StFetch;
        end else if (dec_illegal) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = StFetch;
        end else if (iss_ready) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req     = (state_q == StFetch);
    imem_addr    = pc_q;
    iss_valid    = (state_q == StIssue);
    illegal      = (state_q == StDecode) && dec_illegal;
    iss_alu_op   = iss_q.alu_op;
    iss_rd       = iss_q.rd;
    iss_ra       = iss_q.ra;
    iss_rb       = iss_q.rb;
    iss_imm      = iss_q.imm;
    iss_use_imm  = iss_q.use_imm;
    iss_is_load  = iss_q.is_load;
    iss_is_store = iss_q.is_store;
    iss_pc       = iss_q.pc;
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed scenarios, then randomized memory/execute traffic
// checked by a scoreboard fed from a transaction-level reference model.
module tb_fetch_decode;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, redirect_valid, iss_valid, iss_ready, illegal;
  logic [15:0] imem_addr, imem_data, redirect_pc, iss_imm, iss_pc;
  logic [3:0]  iss_alu_op;
  logic [2:0]  iss_rd, iss_ra, iss_rb;
  logic        iss_use_imm, iss_is_load, iss_is_store;

  fetch_decode #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_alu_op(iss_alu_op), .iss_rd(iss_rd), .iss_ra(iss_ra), .iss_rb(iss_rb),
    .iss_imm(iss_imm), .iss_use_imm(iss_use_imm), .iss_is_load(iss_is_load),
    .iss_is_store(iss_is_store), .iss_pc(iss_pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {KFetch, KIss, KIll} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic [15:0] pc;
    logic [3:0]  alu;
    logic [2:0]  rd, ra, rb;
    logic [15:0] imm;
    logic        ui, ld, st;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;
  int          n_acks = 0;

  // Reference model state: next fetch PC, pending redirect, instruction awaiting issue.
  logic [15:0] m_pc;
  logic        m_pend;
  logic [15:0] m_pend_pc;
  logic        m_have;
  exp_t        m_rec;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t iss_exp(input logic [15:0] pc, input logic [3:0] alu,
                                   input logic [2:0] rd, input logic [2:0] ra,
                                   input logic [2:0] rb, input logic [15:0] imm,
                                   input logic ui, input logic ld, input logic st);
    exp_t e;
    e = '0;
    e.kind = KIss; e.pc = pc; e.alu = alu; e.rd = rd; e.ra = ra; e.rb = rb;
    e.imm = imm; e.ui = ui; e.ld = ld; e.st = st;
    return e;
  endfunction

  function automatic exp_t dut_iss();
    return iss_exp(iss_pc, iss_alu_op, iss_rd, iss_ra, iss_rb, iss_imm,
                   iss_use_imm, iss_is_load, iss_is_store);
  endfunction

  function automatic exp_t kind_only(input kind_e k, input logic [15:0] pc);
    exp_t e;
    e = '0;
    e.kind = k;
    e.pc = pc;
    return e;
  endfunction

  // Expected behaviour of one fetched word, from the ISA opcode table.
  task automatic model_word(input logic [15:0] w);
    int          op;
    logic [15:0] sx, zx, off;
    exp_t        r;
    op  = int'(w[15:11]);
    sx  = {{11{w[4]}}, w[4:0]};
    zx  = {11'b0, w[4:0]};
    off = {{5{w[10]}}, w[10:0]};
    r   = iss_exp(m_pc, 4'd0, w[10:8], w[7:5], w[4:2], 16'd0, 1'b0, 1'b0, 1'b0);
    if (op == 14) begin
      m_pc = m_pc + 16'd1 + off;
      return;
    end
    if (op >= 20) begin
      exp_q.push_back(kind_only(KIll, 16'd0));
      m_pc = m_pc + 16'd1;
      return;
    end
    if (op <= 6) r.alu = 4'(op);
    else if (op <= 13) begin
      r.alu = 4'(op - 7);
      r.ui  = 1'b1;
      r.imm = (op == 7 || op == 8) ? sx : zx;
    end else if (op <= 17) r.alu = 4'(op - 8);
    else begin
      r.ui  = 1'b1;
      r.imm = sx;
      r.st  = (op == 18);
      r.ld  = (op == 19);
    end
    m_rec  = r;
    m_have = 1'b1;
  endtask

  task automatic drive_random();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    iss_ready      = 1'b0;
    imem_data      = 16'($urandom);
    if (imem_req) begin
      if (!m_pend && $urandom_range(0, 7) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom);
        m_pend         = 1'b1;
        m_pend_pc      = redirect_pc;
      end
      if ($urandom_range(0, 2) == 0) begin
        imem_ack = 1'b1;
        n_acks++;
        exp_q.push_back(kind_only(KFetch, m_pc));
        if (m_pend) begin
          m_pc   = m_pend_pc;
          m_pend = 1'b0;
        end else begin
          model_word(imem_data);
        end
      end
    end else if (iss_valid) begin
      check("valid_expected", 64'(m_have), 64'd1);
      iss_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 16'($urandom);
      end
      if (iss_ready) exp_q.push_back(m_rec);
      if (iss_ready || redirect_valid) begin
        m_have = 1'b0;
        m_pc   = redirect_valid ? redirect_pc : m_pc + 16'd1;
      end
    end
  endtask

  task automatic mon_pop(input string name, input exp_t act);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: actual unexpected event %h required no event", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'(act), 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (imem_req && imem_ack) mon_pop("sb_fetch", kind_only(KFetch, imem_addr));
      if (iss_valid && iss_ready) mon_pop("sb_issue", dut_iss());
      if (illegal) mon_pop("sb_illegal", kind_only(KIll, 16'd0));
    end
  end

  task automatic ack(input logic [15:0] w);
    imem_ack  = 1'b1;
    imem_data = w;
    tick();
    imem_ack  = 1'b0;
  endtask

  task automatic accept();
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
  endtask

  initial begin
    imem_ack = 1'b0; imem_data = '0; redirect_valid = 1'b0; redirect_pc = '0; iss_ready = 1'b0;
    repeat (2) tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", iss_valid, 1'b0);
    check("rst_illegal", illegal, 1'b0);
    check("rst_fields", dut_iss(), iss_exp(16'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'd0, 0, 0, 0));
    reset = 1'b0;
    check("idle_req", imem_req, 1'b0);
    tick();
    check("fetch_req", imem_req, 1'b1);
    check("fetch_addr", imem_addr, 16'h0000);
    ack(16'h0128);
    check("decode_valid", iss_valid, 1'b0);
    check("decode_req", imem_req, 1'b0);
    tick();
    check("add_valid", iss_valid, 1'b1);
    check("add_fields", dut_iss(), iss_exp(16'd0, 4'd0, 3'd1, 3'd1, 3'd2, 16'd0, 0, 0, 0));
    accept();
    check("next_req", imem_req, 1'b1);
    check("next_addr", imem_addr, 16'h0001);
    ack(16'h3A3F);
    tick();
    check("addi_fields", dut_iss(), iss_exp(16'd1, 4'd0, 3'd2, 3'd1, 3'd7, 16'hFFFF, 1, 0, 0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_valid", iss_valid, 1'b1);
      check("stall_req", imem_req, 1'b0);
      check("stall_fields", dut_iss(), iss_exp(16'd1, 4'd0, 3'd2, 3'd1, 3'd7, 16'hFFFF, 1, 0, 0));
    end
    accept();
    check("after_stall_addr", imem_addr, 16'h0002);
    ack(16'h4A3F);
    tick();
    check("ori_fields", dut_iss(), iss_exp(16'd2, 4'd2, 3'd2, 3'd1, 3'd7, 16'h001F, 1, 0, 0));
    accept();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    check("pend_req", imem_req, 1'b1);
    check("pend_addr", imem_addr, 16'h0003);
    tick();
    tick();
    ack(16'h0128);
    check("discard_req", imem_req, 1'b1);
    check("discard_addr", imem_addr, 16'h0040);
    tick();
    check("discard_no_valid", iss_valid, 1'b0);
    ack(16'h0128);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0005;
    tick();
    redirect_valid = 1'b0;
    check("redir_iss_valid", iss_valid, 1'b0);
    check("redir_iss_addr", imem_addr, 16'h0005);
    ack(16'h77FF);
    tick();
    check("bri_valid", iss_valid, 1'b0);
    check("bri_req", imem_req, 1'b1);
    check("bri_addr", imem_addr, 16'h0005);
    ack(16'hA800);
    check("ill_pulse", illegal, 1'b1);
    check("ill_valid", iss_valid, 1'b0);
    tick();
    check("ill_drop", illegal, 1'b0);
    check("ill_addr", imem_addr, 16'h0006);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    ack(16'h0128);
    redirect_valid = 1'b0;
    check("same_cycle_redir_addr", imem_addr, 16'hFFFF);
    ack(16'h0128);
    tick();
    check("wrap_fields", dut_iss(), iss_exp(16'hFFFF, 4'd0, 3'd1, 3'd1, 3'd2, 16'd0, 0, 0, 0));
    accept();
    check("wrap_addr", imem_addr, 16'h0000);
    ack(16'h0128);
    tick();
    iss_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h1234;
    tick();
    iss_ready      = 1'b0;
    redirect_valid = 1'b0;
    check("prio_valid", iss_valid, 1'b0);
    check("prio_addr", imem_addr, 16'h1234);
    ack(16'h0128);
    tick();
    check("pre_reset_valid", iss_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", iss_valid, 1'b0);
    check("async_rst_req", imem_req, 1'b0);
    check("async_rst_fields", dut_iss(), iss_exp(16'd0, 4'd0, 3'd0, 3'd0, 3'd0, 16'd0, 0, 0, 0));
    tick();
    reset = 1'b0;
    check("post_rst_idle", imem_req, 1'b0);

    m_pc   = 16'h0000;
    m_pend = 1'b0;
    m_have = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end
    imem_ack = 1'b0; redirect_valid = 1'b0; iss_ready = 1'b0;
    repeat (3) tick();
    mon_en = 1'b0;
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("progress", 64'(n_acks >= 200), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req, output, 1: instruction fetch request.
REQ-005 SHALL have port imem_addr, output, 16: fetch word address (= PC).
REQ-006 SHALL have port imem_ack, input, 1: memory returns imem_data this cycle.
REQ-007 SHALL have port imem_data, input, 16: instruction word.
REQ-008 SHALL have port redirect_valid, input, 1: execute-stage PC redirect.
REQ-009 SHALL have port redirect_pc, input, 16: redirect target.
REQ-010 SHALL have port iss_valid, output, 1: decoded instruction valid to execute stage.
REQ-011 SHALL have port iss_ready, input, 1: execute stage accepts.
REQ-012 SHALL have ports iss_alu_op (output, 4), iss_rd, iss_ra, iss_rb (output, 3 each): ALU op (ADD0 SUB1 OR2 AND3 XOR4 SL5 SR6 GT7 LT8 EQ9) and register indices.
REQ-013 SHALL have ports iss_imm (output, 16), iss_use_imm, iss_is_load, iss_is_store (output, 1 each), iss_pc (output, 16): instruction address.
REQ-014 SHALL have port illegal, output, 1: one-cycle pulse on undefined opcode.

Function
REQ-015 SHALL decode the instruction as opcode=[15:11], rd=[10:8], ra=[7:5], rb=[4:2], imm5=[4:0].
REQ-016 SHALL map opcodes 0-6 to alu_op 0-6, opcodes 15/16/17 to alu_op 7/8/9, with use_imm=0.
REQ-017 SHALL map opcodes 7-13 (ADDI,SUBI,ORI,ANDI,XORI,SLI,SRI) to alu_op 0-6 with use_imm=1; imm sign-extended from imm5 for ADDI/SUBI and zero-extended otherwise.
REQ-018 SHALL decode STW(18)/LDW(19) as alu_op=0, use_imm=1, imm=sign-extended imm5, is_store or is_load respectively; rd is data reg for LDW and source reg for STW.
REQ-019 SHALL handle BRI(14) internally: PC <= PC+1+sext([10:0]); nothing issued.
REQ-020 SHALL treat opcodes 20-31 as illegal: pulse illegal for one cycle in DECODE, PC <= PC+1, nothing issued.
REQ-021 SHALL implement FSM IDLE -> FETCH -> DECODE -> ISSUE -> FETCH; BRI and illegal go DECODE -> FETCH.
REQ-022 SHALL in FETCH hold imem_req=1 with imem_addr=PC stable until imem_ack; on ack capture imem_data into IR, go to DECODE.
REQ-023 SHALL in DECODE register all iss_* fields from IR (one cycle, imem_req=0, iss_valid=0).
REQ-024 SHALL in ISSUE hold iss_valid=1 and all iss_* stable until iss_ready=1; on that edge PC <= PC+1, go to FETCH.
REQ-025 SHALL assert iss_valid exactly 2 cycles after the imem_ack cycle and imem_req the cycle after iss_valid&iss_ready.
REQ-026 SHALL wrap PC modulo 2^16 (16'hFFFF+1 = 16'h0000; branch sums truncated to 16 bits).
REQ-027 SHALL on redirect_valid in DECODE or ISSUE: PC <= redirect_pc, drop iss_valid next cycle, discard the instruction, go to FETCH.
REQ-028 SHALL on redirect_valid in FETCH: latch redirect_pc as pending, keep the request until ack, discard the returned word, then fetch from the pending PC.
REQ-029 SHALL give redirect priority over iss_ready acceptance in the same cycle: instruction still counts as accepted, but PC <= redirect_pc.
REQ-030 SHALL in IDLE (exactly one cycle after reset release) assert no outputs, then enter FETCH.

Reset
REQ-031 SHALL on reset asynchronously force state=IDLE, PC=RESET_PC, IR=0, pending redirect cleared, imem_req=0, iss_valid=0, illegal=0, all iss_* fields 0.
REQ-032 SHALL on reset mid-fetch or mid-issue abandon the transaction with no further req/valid until re-entering FETCH.

Verification
REQ-033 SHALL cover: reset release, ack 1 cycle later with 16'h0128 (ADD r1,r1,r2) -> iss_valid 2 cycles after ack, alu_op=0, rd=1, ra=1, rb=2, iss_pc=0.
REQ-034 SHALL cover: 16'h3A3F (ADDI r2,r1,-1) -> use_imm=1, iss_imm=16'hFFFF; 16'h4A3F (ORI) -> iss_imm=16'h001F.
REQ-035 SHALL cover: BRI 16'h77FF at PC=5 -> no iss_valid, next imem_addr=5; PC=16'hFFFF ADD accepted -> next imem_addr=0.
REQ-036 SHALL cover: iss_ready low 4 cycles -> iss_valid and fields stable 4 cycles; no imem_req until accept.
REQ-037 SHALL cover: redirect_valid=1, redirect_pc=16'h0040 during FETCH with ack delayed 3 cycles -> returned word discarded, next imem_addr=16'h0040.
REQ-038 SHALL cover: opcode 21 (16'hA800) -> illegal pulse 1 cycle, no iss_valid, next imem_addr=PC+1.
